spi_reg_sequencer: RTL

//  Upstream command stage for spi_master: accepts register read/write requests on a

---
 rtl/spi_reg_sequencer_if.sv | 32 +++
 rtl/spi_reg_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/spi_reg_sequencer_if.sv
// Request/response and spi_master-facing signals of the register sequencer; slave = sequencer side.
// No timing of its own: latency and backpressure are set by the module that owns the slave modport.
interface spi_reg_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  seq_busy;
    logic [DATA_WIDTH-1:0] m_tx_data;
    logic                  m_start;
    logic [DATA_WIDTH-1:0] m_rx_data;
    logic                  m_done;
    logic                  m_busy;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, rsp_ready, m_rx_data, m_done, m_busy,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, seq_busy, m_tx_data, m_start
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, rsp_ready, m_rx_data, m_done, m_busy,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, seq_busy, m_tx_data, m_start
    );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Queues register requests and runs each as a command byte then a data byte on spi_master.
// Latency: push->m_start 2 cycles, m_done->next m_start 2, last m_done->rsp_valid 1; req_ready drops when full, response held until rsp_ready.
module spi_reg_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 7,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                clk,
    input logic                rst_n,
    spi_reg_sequencer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WAIT_CMD, S_DATA, S_WAIT_DATA, S_RESP
    } state_t;

    state_t                r_state, w_next;
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [PW:0]           r_count;
    logic                  r_rw;
    logic [DATA_WIDTH-1:0] r_wdata, r_tx, r_rdata;
    logic                  r_start, r_err;
    logic [TW-1:0]         r_timer;

    logic [EW-1:0] w_head;
    logic          w_full, w_empty, w_push, w_pop, w_load_data, w_ok, w_timeout, w_expired;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.req_valid && !w_full;
    assign w_expired = (r_timer == TMO_LAST);

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_load_data = 1'b0;
        w_ok        = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !bus.m_busy) begin
                    w_pop  = 1'b1;
                    w_next = S_CMD;
                end
            end
            S_CMD:      w_next = S_WAIT_CMD;
            // m_done is tested first so a done on the expiry cycle is never an error
            S_WAIT_CMD: begin
                if (bus.m_done) begin
                    w_next = S_DATA;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_DATA: begin
                w_load_data = 1'b1;
                w_next      = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (bus.m_done) begin
                    w_ok   = 1'b1;
                    w_next = S_RESP;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.req_rw, bus.req_addr, bus.req_wdata};
    end

    // Command byte launches on entry to CMD; data byte launches on leaving DATA (one gap cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_tx     <= '0;
            r_start  <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_start <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_rw     <= w_head[EW-1];
                r_wdata  <= w_head[DATA_WIDTH-1:0];
                r_tx     <= DATA_WIDTH'(w_head[EW-1:DATA_WIDTH]);
                r_start  <= 1'b1;
            end
            if (w_load_data) begin
                r_tx    <= r_rw ? '0 : r_wdata;
                r_start <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (r_state == S_WAIT_CMD || r_state == S_WAIT_DATA) r_timer <= r_timer + TW'(1);
            else                                                  r_timer <= '0;
            if (w_ok) begin
                r_rdata <= bus.m_rx_data;
                r_err   <= 1'b0;
            end
            if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.seq_busy  = (r_state != S_IDLE) || !w_empty;
    assign bus.m_tx_data = r_tx;
    assign bus.m_start   = r_start;
endmodule
